// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared constants and state encoding for the fetch-PC redirect controller.
package pc_redirect_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;
    localparam logic [31:0] PC_STEP            = 32'd4;

    typedef enum logic {
        PCS_RUN   = 1'b0,
        PCS_REDIR = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_next_mux.sv
// Priority select of the next fetch PC and delay-slot tag (purely combinational).
module pc_next_mux
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        in_redir,
    input  logic [31:0] pc_cur,
    input  logic        bd_cur,
    input  logic        stall,
    input  logic        is_ctrl_d,
    input  logic        br,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc_next,
    output logic        bd_next,
    output logic        redirect
);

    logic [31:0] pc_seq;

    assign pc_seq = pc_cur + PC_STEP;

    always_comb begin
        pc_next  = pc_seq;
        bd_next  = is_ctrl_d;
        redirect = 1'b0;
        if (exc_req) begin
            pc_next  = EXC_VECTOR;
            bd_next  = 1'b0;
            redirect = 1'b1;
        end else if (in_redir) begin
            // D holds a bubble after a redirect, so nothing in it can steer fetch.
            pc_next = pc_seq;
            bd_next = 1'b0;
        end else if (eret) begin
            pc_next  = epc;
            bd_next  = 1'b0;
            redirect = 1'b1;
        end else if (stall) begin
            pc_next = pc_cur;
            bd_next = bd_cur;
        end else if (jr) begin
            pc_next = jr_target;
        end else if (jump) begin
            pc_next = jump_target;
        end else if (br) begin
            pc_next = br_target;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequences branches, jumps, exceptions and ERET for the F stage.
// Optional fetch address-error output enabled by defining PC_ALIGN_CHECK_EN.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
`ifdef PC_ALIGN_CHECK_EN
    ,
    parameter logic [31:0] PC_LO      = 32'h0000_3000,
    parameter logic [31:0] PC_HI      = 32'h0000_6FFC
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        is_ctrl_d,
    input  logic        br,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc_f,
    output logic        bd_f,
    output logic        flush_fd,
    output logic        redir_f
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        exc_adel_f
`endif
);

    pc_state_e   state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        bd_reg, bd_next;
    logic        redirect;

    pc_next_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .in_redir    (state_reg == PCS_REDIR),
        .pc_cur      (pc_reg),
        .bd_cur      (bd_reg),
        .stall       (stall),
        .is_ctrl_d   (is_ctrl_d),
        .br          (br),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .jr          (jr),
        .jr_target   (jr_target),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .pc_next     (pc_next),
        .bd_next     (bd_next),
        .redirect    (redirect)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= PCS_RUN;
            pc_reg    <= RESET_PC;
            bd_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            bd_reg    <= bd_next;
        end
    end

    // REDIR lasts one cycle unless another exception re-enters it.
    always_comb begin
        state_next = PCS_RUN;
        if (redirect) begin
            state_next = PCS_REDIR;
        end
    end

    assign pc_f     = pc_reg;
    assign bd_f     = bd_reg;
    assign redir_f  = (state_reg == PCS_REDIR);
    assign flush_fd = redirect & ~reset;

`ifdef PC_ALIGN_CHECK_EN
    logic bad_pc;

    assign bad_pc     = (pc_reg[1:0] != 2'b00) | (pc_reg < PC_LO) | (pc_reg > PC_HI);
    // The fetch being flushed never retires, so it must not raise AdEL.
    assign exc_adel_f = bad_pc & ~flush_fd;
`endif

endmodule
